// File: rtl/inst_fetch_fifo.sv
// Instruction buffer between IF and ID: first-word-fall-through FIFO with
// almost-full stall request, flush, and a sticky overflow flag.
module inst_fetch_fifo #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int AFULL_TH = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          id_stall,
    input  logic          push_valid,
    input  logic [31:0]   push_pc,
    input  logic [31:0]   push_inst,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    output logic [AW:0]   count,
    output logic          stallreq_for_fifo,
    output logic          overflow_err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_TH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q;
    logic          pop, accept;
    logic [63:0]   head;

    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_valid = (count_q != '0) & ~flush;
        out_pc    = out_valid ? head[63:32] : '0;
        out_inst  = out_valid ? head[31:0]  : '0;
        pop       = out_valid & ~id_stall;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        accept    = push_valid & ~flush & ((count_q < DEPTH_C) | pop);
    end

    always_comb begin
        count_d = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Sticky: survives flush, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (push_valid & ~flush & ~accept)
            ovf_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem_q[wr_ptr_q] <= {push_pc, push_inst};
    end

    assign count             = count_q;
    assign stallreq_for_fifo = (count_q >= AFULL_C);
    assign overflow_err      = ovf_q;

endmodule

// File: tb/tb_inst_fetch_fifo.sv
// Self-checking bench for inst_fetch_fifo: a queue scoreboard holds pushed
// entries and is compared against the head whenever the DUT presents one.
module tb_inst_fetch_fifo;

    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int AFULL_TH = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          id_stall = 1'b0;
    logic          push_valid = 1'b0;
    logic [31:0]   push_pc = '0;
    logic [31:0]   push_inst = '0;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic [AW:0]   count;
    logic          stallreq_for_fifo;
    logic          overflow_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [63:0] sb[$];
    logic        m_ovf = 1'b0;

    inst_fetch_fifo #(.DEPTH(DEPTH), .AW(AW), .AFULL_TH(AFULL_TH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_stall(id_stall),
        .push_valid(push_valid), .push_pc(push_pc), .push_inst(push_inst),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .count(count), .stallreq_for_fifo(stallreq_for_fifo),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // Called #1 after a rising edge; checks outputs mid-cycle, updates the
    // model, then advances to #1 after the next rising edge.
    task automatic step(input logic pv, input logic [31:0] pc, input logic stall, input logic fl);
        logic        ev, pop, acc;
        logic [31:0] inst;
        inst       = $urandom;
        push_valid = pv;
        push_pc    = pc;
        push_inst  = inst;
        id_stall   = stall;
        flush      = fl;
        #3;
        ev = (sb.size() != 0) && !fl;
        chk("out_valid", 64'(out_valid), 64'(ev));
        chk("out_pc",   64'(out_pc),   ev ? 64'(sb[0][63:32]) : 64'd0);
        chk("out_inst", 64'(out_inst), ev ? 64'(sb[0][31:0])  : 64'd0);
        chk("count",    64'(count),    64'(sb.size()));
        chk("stallreq", 64'(stallreq_for_fifo), 64'(sb.size() >= AFULL_TH));
        chk("overflow", 64'(overflow_err), 64'(m_ovf));
        pop = ev && !stall;
        acc = pv && !fl && ((sb.size() < DEPTH) || pop);
        if (pv && !fl && !acc) m_ovf = 1'b1;
        if (fl) sb.delete();
        else begin
            if (pop) void'(sb.pop_front());
            if (acc) sb.push_back({pc, inst});
        end
        @(posedge clk);
        #1;
    endtask

    // Pulses reset between edges and checks the asynchronous clear.
    task automatic pulse_reset();
        push_valid = 1'b0;
        flush      = 1'b0;
        rst        = 1'b1;
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc",    64'(out_pc), 64'd0);
        chk("rst_inst",  64'(out_inst), 64'd0);
        chk("rst_stall", 64'(stallreq_for_fifo), 64'd0);
        chk("rst_ovf",   64'(overflow_err), 64'd0);
        sb.delete();
        m_ovf = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        pulse_reset();

        // Fill 6 with ID stalled, then drain in order.
        for (int i = 0; i < 6; i++) step(1'b1, 32'hBFC00000 + 32'(4*i), 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, push with pop (count holds), then overflow.
        for (int i = 0; i < 8; i++) step(1'b1, 32'h00400000 + 32'(4*i), 1'b1, 1'b0);
        step(1'b1, 32'h00400020, 1'b0, 1'b0);
        step(1'b1, 32'h00400024, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Drain to 5, flush against push, then check the redirect target.
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h00500000, 1'b0, 1'b1);
        step(1'b1, 32'h80000180, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        // Wrap-around streaming with pops lagging by two cycles.
        pulse_reset();
        for (int i = 0; i < 24; i++)
            step(i < 20, 32'h00001000 + 32'(4*i), i < 2, 1'b0);
        chk("wrap_ovf", 64'(overflow_err), 64'd0);

        // Overflow, drain to 4, then asynchronous reset mid-operation.
        for (int i = 0; i < 9; i++) step(1'b1, 32'h00002000 + 32'(4*i), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, i == 4, 1'b0);
        pulse_reset();
        step(1'b1, 32'h00003000, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
